// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared constants and FSM encoding for the APU register writer
//
// Purpose: register offsets (relative to $4000) decoded by apu_reg_writer and
// the two-state parser encoding.
package apu_pkg;

  localparam logic [4:0] APU_TRI_LINEAR = 5'h08;
  localparam logic [4:0] APU_TRI_LO     = 5'h0A;
  localparam logic [4:0] APU_TRI_HI     = 5'h0B;
  localparam logic [4:0] APU_STATUS     = 5'h15;
  localparam logic [4:0] APU_FRAME      = 5'h17;

  typedef enum logic {
    ST_ADDR = 1'b0,  // waiting for an address byte
    ST_DATA = 1'b1   // offset latched, waiting for its data byte
  } state_t;

endpackage

// File: rtl/apu_reg_writer_byte_timeout.sv
// rtl/apu_reg_writer_byte_timeout.sv - saturating idle counter with one-cycle expiry
//
// Purpose: counts idle cycles between an address byte and its data byte.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   clear        hold the count at 0
//   enable       count one idle cycle
//   expire       high in the enabled cycle whose increment reaches TIMEOUT-1
module byte_timeout #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ARM  = CW'(TIMEOUT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the increment into LAST; saturation keeps it from refiring.
  assign expire = enable && (count == ARM);

endmodule

// File: rtl/apu_reg_writer.sv
// rtl/apu_reg_writer.sv - address/data byte parser driving triangle and frame registers
//
// Purpose: turns received (offset, data) byte pairs into APU register writes.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   reg_4008/400A/400B    held triangle register bytes
//   reg_event             one-cycle pulse per $400B write
//   tri_enable            $4015 bit 2
//   frame_mode            $4017 bit 7
//   irq_inhibit           $4017 bit 6
//   frame_reset           one-cycle pulse per $4017 write
//   frame_error           one-cycle pulse on a bad address byte or timeout
module apu_reg_writer
  import apu_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] reg_4008,
  output logic [7:0] reg_400A,
  output logic [7:0] reg_400B,
  output logic       reg_event,
  output logic       tri_enable,
  output logic       frame_mode,
  output logic       irq_inhibit,
  output logic       frame_reset,
  output logic       frame_error
);

  state_t     state;
  state_t     state_next;
  logic [4:0] offset_q;

  logic       addr_ok;
  logic       take_addr;
  logic       bad_addr;
  logic       do_write;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       expire;

  assign addr_ok = (rx_data[7:5] == 3'b000);

  byte_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ADDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ADDR: if (rx_valid && addr_ok) state_next = ST_DATA;
      ST_DATA: if (rx_valid || expire)  state_next = ST_ADDR;
      default: state_next = ST_ADDR;
    endcase
  end

  // Output decode. A byte arriving in the expiry cycle wins because the
  // counter is only enabled on idle cycles.
  always_comb begin
    take_addr  = 1'b0;
    bad_addr   = 1'b0;
    do_write   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    case (state)
      ST_ADDR: begin
        tmr_clear = 1'b1;
        take_addr = rx_valid && addr_ok;
        bad_addr  = rx_valid && !addr_ok;
      end
      ST_DATA: begin
        do_write   = rx_valid;
        tmr_enable = !rx_valid;
      end
      default: tmr_clear = 1'b1;
    endcase
  end

  // Register file and pulses; everything lands one cycle after the strobe,
  // so reg_event coincides with the new reg_400B value.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q    <= '0;
      reg_4008    <= '0;
      reg_400A    <= '0;
      reg_400B    <= '0;
      reg_event   <= 1'b0;
      tri_enable  <= 1'b0;
      frame_mode  <= 1'b0;
      irq_inhibit <= 1'b0;
      frame_reset <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      reg_event   <= 1'b0;
      frame_reset <= 1'b0;
      frame_error <= bad_addr || expire;
      if (take_addr) begin
        offset_q <= rx_data[4:0];
      end
      if (do_write) begin
        case (offset_q)
          APU_TRI_LINEAR: reg_4008 <= rx_data;
          APU_TRI_LO:     reg_400A <= rx_data;
          APU_TRI_HI: begin
            reg_400B  <= rx_data;
            reg_event <= 1'b1;
          end
          APU_STATUS:     tri_enable <= rx_data[2];
          APU_FRAME: begin
            frame_mode  <= rx_data[7];
            irq_inhibit <= rx_data[6];
            frame_reset <= 1'b1;
          end
          default: ;  // unmapped offset: data consumed silently
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apu_reg_writer.sv
// tb/tb_apu_reg_writer.sv - directed self-checking bench for apu_reg_writer
module tb_apu_reg_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] reg_4008;
  logic [7:0] reg_400A;
  logic [7:0] reg_400B;
  logic       reg_event;
  logic       tri_enable;
  logic       frame_mode;
  logic       irq_inhibit;
  logic       frame_reset;
  logic       frame_error;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  apu_reg_writer #(
    .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .reg_4008    (reg_4008),
    .reg_400A    (reg_400A),
    .reg_400B    (reg_400B),
    .reg_event   (reg_event),
    .tri_enable  (tri_enable),
    .frame_mode  (frame_mode),
    .irq_inhibit (irq_inhibit),
    .frame_reset (frame_reset),
    .frame_error (frame_error)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
  endtask

  // Drive on the falling edge; the next rising edge captures the byte.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_data  = 8'h00;
    rx_valid = 1'b0;
  endtask

  logic ev_seen;

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_4008", reg_4008, 8'h00);
    check("rst_400B", reg_400B, 8'h00);
    check("rst_pulses", {5'b0, reg_event, frame_reset, frame_error}, 8'h00);

    // Write trio, back-to-back
    strobe(8'h08); strobe(8'h81);
    strobe(8'h0A); strobe(8'hFD);
    strobe(8'h0B); strobe(8'h0A);
    check("trio_pre_event", reg_event, 8'h00);
    check("trio_pre_400B", reg_400B, 8'h00);
    idle();
    check("trio_4008", reg_4008, 8'h81);
    check("trio_400A", reg_400A, 8'hFD);
    check("trio_400B", reg_400B, 8'h0A);
    check("trio_event", reg_event, 8'h01);
    idle();
    check("trio_event_off", reg_event, 8'h00);

    // Invalid address then a good pair
    strobe(8'h48); strobe(8'h0A);
    check("inv_err", frame_error, 8'h01);
    strobe(8'h55);
    check("inv_err_once", frame_error, 8'h00);
    idle();
    check("inv_400A", reg_400A, 8'h55);

    // Timeout: error visible on the 16th idle cycle, no event
    strobe(8'h0B);
    ev_seen = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      idle();
      ev_seen |= reg_event;
      if (k == 15) check("to_err_early", frame_error, 8'h00);
      if (k == 16) check("to_err", frame_error, 8'h01);
      if (k == 17) check("to_err_once", frame_error, 8'h00);
    end
    check("to_no_event", ev_seen, 8'h00);
    check("to_400B_kept", reg_400B, 8'h0A);
    strobe(8'h08); strobe(8'h12); idle();
    check("to_resync_4008", reg_4008, 8'h12);

    // Data on the expiry cycle is accepted
    strobe(8'h0B);
    repeat (14) idle();
    strobe(8'h33);
    idle();
    check("col_400B", reg_400B, 8'h33);
    check("col_event", reg_event, 8'h01);
    check("col_no_err", frame_error, 8'h00);
    idle();
    check("col_no_err_late", frame_error, 8'h00);

    // Status and frame writes
    strobe(8'h15); strobe(8'h04); idle();
    check("st_tri_enable", tri_enable, 8'h01);
    strobe(8'h17); strobe(8'hC0); idle();
    check("fr_mode", frame_mode, 8'h01);
    check("fr_irq", irq_inhibit, 8'h01);
    check("fr_reset", frame_reset, 8'h01);
    idle();
    check("fr_reset_once", frame_reset, 8'h00);
    strobe(8'h10); strobe(8'hFF); idle();
    check("unmap_pulses", {5'b0, reg_event, frame_reset, frame_error}, 8'h00);
    check("unmap_4008", reg_4008, 8'h12);
    check("unmap_400A", reg_400A, 8'h55);
    check("unmap_400B", reg_400B, 8'h33);
    check("unmap_flags", {5'b0, tri_enable, frame_mode, irq_inhibit}, 8'h07);

    // Reset mid-frame
    strobe(8'h0B);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_4008", reg_4008, 8'h00);
    check("mr_400A", reg_400A, 8'h00);
    check("mr_400B", reg_400B, 8'h00);
    check("mr_flags", {5'b0, tri_enable, frame_mode, irq_inhibit}, 8'h00);
    check("mr_pulses", {5'b0, reg_event, frame_reset, frame_error}, 8'h00);
    strobe(8'h22); idle();
    check("mr_err", frame_error, 8'h01);
    check("mr_400B_kept", reg_400B, 8'h00);
    check("mr_no_event", reg_event, 8'h00);
    idle();
    check("mr_err_once", frame_error, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apu_reg_writer.md
# apu_reg_writer

Byte-stream parser that turns address/data pairs from the serial receiver into APU register writes for the triangle channel and frame control. Sits between the UART receiver and the triangle generator. Drives the held register bytes `reg_4008`, `reg_400A` and `reg_400B`, plus the one-cycle `reg_event` strobe that the triangle channel uses to reload its length counter. Also decodes `$4015` and `$4017`.

## Interface
Parameters:
- `TIMEOUT`, default 65535: idle clocks allowed between an address byte and its data byte before the parser resyncs. Must be at least 2.

Ports:
- `clk` input 1: system clock, 1.79 MHz APU rate.
- `reset` input 1: reset, synchronous, active-high.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid while it is high.
- `reg_4008` output 8: triangle linear counter control.
- `reg_400A` output 8: triangle period low.
- `reg_400B` output 8: triangle length select and period high.
- `reg_event` output 1: one-cycle pulse on every `$400B` write.
- `tri_enable` output 1: `$4015` bit 2.
- `frame_mode` output 1: `$4017` bit 7.
- `irq_inhibit` output 1: `$4017` bit 6.
- `frame_reset` output 1: one-cycle pulse on every `$4017` write.
- `frame_error` output 1: one-cycle pulse on an invalid address byte or a timeout.

## Operation
- Every output resets to 0 and the FSM resets to ADDR.
- FSM states:
  - ADDR: waiting for an address byte.
  - DATA: holding a latched 5-bit offset and waiting for the data byte.
- ADDR, `rx_valid` high:
  - `rx_data[7:5]==0`: latch `rx_data[4:0]` as the offset (target `$4000+offset`), go to DATA, clear the timeout counter.
  - Otherwise: drop the byte, stay in ADDR, pulse `frame_error`.
- DATA, `rx_valid` high: write `rx_data` to the decoded target, return to ADDR.
  - Offset `0x08` → `reg_4008`.
  - `0x0A` → `reg_400A`.
  - `0x0B` → `reg_400B` and pulse `reg_event`.
  - `0x15` → `tri_enable` ← `rx_data[2]`.
  - `0x17` → `frame_mode` ← bit 7, `irq_inhibit` ← bit 6, pulse `frame_reset`.
  - Any other offset: data is consumed with no effect and no error.
- DATA, `rx_valid` low: the timeout counter increments.
  - When the counter reaches `TIMEOUT-1`, return to ADDR and pulse `frame_error`.
- Timeout counter: width `$clog2(TIMEOUT)`, saturates at `TIMEOUT-1`, held at 0 while in ADDR.
- A data byte with bit 7 set is legal; the data byte is never range-checked.

## Timing
- Register latency: a data byte strobed in cycle N updates the target register at the end of cycle N. The new value is visible in cycle N+1.
- `reg_event` and `frame_reset` are high in cycle N+1 only, coincident with the new register value.
  - This lets the triangle length lookup use the new `reg_400B` on the `reg_event` edge.
- `frame_error` is high for exactly one cycle: the cycle after the offending byte, or the cycle after the counter reaches `TIMEOUT-1`.
- Simultaneous events: if `rx_valid` is high in the cycle the counter would expire, the byte is accepted as data and no error is raised.
- Back-to-back `rx_valid` on consecutive cycles is legal. The FSM has no dead cycle: address at N, data at N+1, register visible at N+2.
- Reset mid-frame: a pending offset is discarded and no pulse is emitted in the reset cycle or the cycle after.
- Repeated `$400B` writes produce one `reg_event` per write, even when the value is unchanged.

## Structure
- Package `apu_pkg` holds:
  - Offset constants: `APU_TRI_LINEAR=5'h08`, `APU_TRI_LO=5'h0A`, `APU_TRI_HI=5'h0B`, `APU_STATUS=5'h15`, `APU_FRAME=5'h17`.
  - The FSM state encoding.
- One sub-module, `byte_timeout`: clear/enable/expire counter parameterised by `TIMEOUT`, with a saturating count and a one-cycle `expire` output.
- Address decode and the register file stay in `apu_reg_writer`.

## Test plan
- Write trio: bytes `0x08,0x81`, `0x0A,0xFD`, `0x0B,0x0A`, back-to-back → `reg_4008=0x81`, `reg_400A=0xFD`, `reg_400B=0x0A`. `reg_event` high exactly one cycle, the same cycle `reg_400B` first reads `0x0A`.
- Invalid address: byte `0x48` in ADDR → `frame_error` pulses once, FSM stays in ADDR. A following `0x0A,0x55` writes `reg_400A=0x55`.
- Timeout: `TIMEOUT=16`, byte `0x0B`, then idle for 16 cycles → `frame_error` pulses on the 16th idle cycle and no `reg_event` fires. A following `0x08,0x12` writes `reg_4008`.
- Expiry collision: `TIMEOUT=16`, byte `0x0B`, then data `0x33` strobed on the 15th idle cycle (the cycle the counter would expire) → `reg_400B=0x33`, `reg_event` pulses, no `frame_error`.
- Status and frame writes:
  - `0x15,0x04` → `tri_enable=1`.
  - `0x17,0xC0` → `frame_mode=1`, `irq_inhibit=1`, `frame_reset` pulses once.
  - `0x10,0xFF` → no output changes, no error.
- Reset: after address byte `0x0B`, assert `reset` for one cycle, then send `0x22` → all outputs 0. `0x22` is treated as an address byte (rejected with `frame_error`), not as data.
